// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand bypass selects, load-use/branch stalls, jump bubbles,
// data-memory wait handling with timeout, and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16,
    parameter int MEM_TO = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              usesrsD,
    input  logic              usesrtD,
    input  logic              branchD,
    input  logic              jumpD,
    input  logic              jumpregD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic [1:0]        memtoregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic [1:0]        memtoregM,
    input  logic              memreqM,
    input  logic              dmem_ack,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    input  logic              clr_cnt,
    output logic              stall_F,
    output logic              stall_D,
    output logic              stall_E,
    output logic              stall_M,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_W,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic [1:0]        forwardAD,
    output logic [1:0]        forwardBD,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              mem_err
);

    localparam int WAIT_W = (MEM_TO < 2) ? 1 : $clog2(MEM_TO + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TO - 1);

    typedef enum logic [1:0] {RUN = 2'd0, JBUB = 2'd1, MWAIT = 2'd2} stateT;

    stateT             stateReg;
    stateT             stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic              timeout;

    // Register 0 is hard-wired, so it never produces a dependency.
    function automatic logic regMatch(input logic [REG_AW-1:0] src,
                                      input logic [REG_AW-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    logic [3:0][REG_AW-1:0] fwdSrc;
    logic [3:0][1:0]        fwdSel;

    assign fwdSrc[0] = rsE;
    assign fwdSrc[1] = rtE;
    assign fwdSrc[2] = rsD;
    assign fwdSrc[3] = rtD;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gFwd
            assign fwdSel[gi] =
                (regwriteM && regMatch(fwdSrc[gi], writeregM)) ?
                    ((memtoregM == 2'b10) ? 2'b11 : 2'b10) :
                (regwriteW && regMatch(fwdSrc[gi], writeregW)) ? 2'b01 : 2'b00;
        end
    endgenerate

    assign forwardAE = fwdSel[0];
    assign forwardBE = fwdSel[1];
    assign forwardAD = fwdSel[2];
    assign forwardBD = fwdSel[3];

    logic rsHitE, rtHitE, rsHitM, rtHitM;
    logic memWait, loadUse, brDep, isJump, anyStall;

    assign rsHitE  = usesrsD && regMatch(rsD, writeregE);
    assign rtHitE  = usesrtD && regMatch(rtD, writeregE);
    assign rsHitM  = usesrsD && regMatch(rsD, writeregM);
    assign rtHitM  = usesrtD && regMatch(rtD, writeregM);

    assign memWait = memreqM && !dmem_ack;
    assign loadUse = (memtoregE == 2'b01) && regwriteE && (rsHitE || rtHitE);
    assign brDep   = (branchD || jumpregD) &&
                     ((regwriteE && (rsHitE || rtHitE)) ||
                      ((memtoregM == 2'b01) && (rsHitM || rtHitM)));
    assign isJump  = jumpD || jumpregD;

    always_comb begin
        stateNext = stateReg;
        stall_F   = 1'b0;
        stall_D   = 1'b0;
        stall_E   = 1'b0;
        stall_M   = 1'b0;
        flush_D   = 1'b0;
        flush_E   = 1'b0;
        flush_W   = 1'b0;
        timeout   = 1'b0;
        case (stateReg)
            MWAIT: begin
                stateNext = RUN;
                if (!dmem_ack) begin
                    {stall_F, stall_D, stall_E, stall_M, flush_W} = 5'b11111;
                    // Last permitted wait cycle: flag the error and let the pipe go.
                    if (waitCnt == WAIT_LAST) begin
                        timeout = 1'b1;
                    end else begin
                        stateNext = MWAIT;
                    end
                end
            end
            default: begin
                stateNext = RUN;
                if (memWait) begin
                    {stall_F, stall_D, stall_E, stall_M, flush_W} = 5'b11111;
                    stateNext = MWAIT;
                end else if (loadUse || brDep) begin
                    {stall_F, stall_D, flush_E} = 3'b111;
                end else if (isJump && (stateReg == RUN)) begin
                    // JBUB masks the still-visible jump for its one bubble cycle.
                    flush_D   = 1'b1;
                    stateNext = JBUB;
                end
            end
        endcase
    end

    assign anyStall = stall_F || stall_D || stall_E || stall_M;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg  <= RUN;
            waitCnt   <= '0;
            stall_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            if ((stateReg == MWAIT) && (stateNext == MWAIT)) begin
                waitCnt <= waitCnt + WAIT_W'(1);
            end else begin
                waitCnt <= '0;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
            if (clr_cnt) begin
                stall_cnt <= '0;
            end else if (anyStall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks of hazard_ctrl: bypass priority, stall/flush hazards, memory wait/timeout,
// and stall counter saturation/clear/reset behaviour (narrow counter to reach saturation fast).
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       usesrsD, usesrtD, branchD, jumpD, jumpregD;
    logic       regwriteE, regwriteM, regwriteW;
    logic [1:0] memtoregE, memtoregM;
    logic       memreqM, dmem_ack, clr_cnt;
    logic       stall_F, stall_D, stall_E, stall_M;
    logic       flush_D, flush_E, flush_W;
    logic [1:0] forwardAE, forwardBE, forwardAD, forwardBD;
    logic [3:0] stall_cnt;
    logic       mem_err;

    int tests = 0;
    int fails = 0;

    hazard_ctrl #(.REG_AW(5), .CNT_W(4), .MEM_TO(15)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .usesrsD(usesrsD), .usesrtD(usesrtD),
        .branchD(branchD), .jumpD(jumpD), .jumpregD(jumpregD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memtoregE(memtoregE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .memreqM(memreqM), .dmem_ack(dmem_ack),
        .writeregW(writeregW), .regwriteW(regwriteW), .clr_cnt(clr_cnt),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .stall_cnt(stall_cnt), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) $display("[TB] ok   %s = %0h", tag, obs);
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clrIn();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        usesrsD = 0; usesrtD = 0; branchD = 0; jumpD = 0; jumpregD = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 2'b00; memtoregM = 2'b00;
        memreqM = 0; dmem_ack = 0; clr_cnt = 0;
    endtask

    // stalls are checked as {F,D,E,M}, flushes as {D,E,W}
    initial begin
        reset = 1'b0;
        clrIn();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_err", 32'(mem_err), 0);
        chk("rst_stall", 32'({stall_F, stall_D, stall_E, stall_M}), 0);
        chk("rst_flush", 32'({flush_D, flush_E, flush_W}), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Forwarding priority
        rsE = 3; writeregM = 3; regwriteM = 1; memtoregM = 2'b10;
        writeregW = 3; regwriteW = 1; rsD = 3;
        #1;
        chk("fwdAE_c0", 32'(forwardAE), 3);
        chk("fwdAD_c0", 32'(forwardAD), 3);
        memtoregM = 2'b00; #1;
        chk("fwdAE_mem", 32'(forwardAE), 2);
        regwriteM = 0; #1;
        chk("fwdAE_wb", 32'(forwardAE), 1);
        rsE = 0; #1;
        chk("fwdAE_r0", 32'(forwardAE), 0);
        rtE = 3; #1;
        chk("fwdBE_wb", 32'(forwardBE), 1);
        writeregW = 0; rtD = 0; #1;
        chk("fwdBD_r0", 32'(forwardBD), 0);
        clrIn();

        // Load-use
        memtoregE = 2'b01; regwriteE = 1; writeregE = 5; rtD = 5; usesrtD = 1;
        #1;
        chk("lu_stall", 32'({stall_F, stall_D, stall_E, stall_M}), 4'b1100);
        chk("lu_flush", 32'({flush_D, flush_E, flush_W}), 3'b010);
        tick();
        chk("lu_cnt", 32'(stall_cnt), 1);
        usesrtD = 0; #1;
        chk("lu_unused", 32'({stall_F, stall_D, flush_E}), 0);
        tick();
        chk("lu_cnt_hold", 32'(stall_cnt), 1);
        writeregE = 0; rtD = 0; usesrtD = 1; #1;
        chk("lu_r0", 32'({stall_F, stall_D, flush_E}), 0);
        clrIn();

        // Load-use outranks jump
        memtoregE = 2'b01; regwriteE = 1; writeregE = 5; rsD = 5; usesrsD = 1; jumpD = 1;
        #1;
        chk("lu_vs_jmp", 32'({flush_D, flush_E, flush_W}), 3'b010);
        tick();
        chk("lu_vs_jmp_cnt", 32'(stall_cnt), 2);
        clrIn();

        // Branch after load in M, then branch after ALU op in E
        branchD = 1; rsD = 7; usesrsD = 1; rtD = 2; usesrtD = 1;
        memtoregM = 2'b01; writeregM = 7;
        #1;
        chk("br_ldM", 32'({stall_F, stall_D, stall_E, stall_M}), 4'b1100);
        tick();
        chk("br_ldM_cnt", 32'(stall_cnt), 3);
        memtoregM = 2'b00; writeregM = 0; regwriteE = 1; writeregE = 2;
        #1;
        chk("br_aluE", 32'({stall_F, stall_D, flush_E}), 3'b111);
        tick();
        chk("br_aluE_cnt", 32'(stall_cnt), 4);
        branchD = 0; #1;
        chk("nobr", 32'({stall_F, stall_D, flush_E}), 0);
        clrIn();

        // Jump held two cycles: flush only in the first, then RUN again
        jumpD = 1; #1;
        chk("jmp_flush", 32'({flush_D, flush_E, flush_W}), 3'b100);
        chk("jmp_nostall", 32'(stall_F), 0);
        tick();
        chk("jbub_flush", 32'({flush_D, flush_E, flush_W}), 0);
        tick();
        chk("jmp_rerun", 32'(flush_D), 1);
        jumpD = 0; #1;
        chk("jmp_off", 32'(flush_D), 0);
        tick();
        chk("jmp_cnt", 32'(stall_cnt), 4);

        // Memory wait, ack after 3 stalled cycles
        clr_cnt = 1; tick(); clr_cnt = 0;
        chk("clr_cnt", 32'(stall_cnt), 0);
        memreqM = 1; dmem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw_stall%0d", i), 32'({stall_F, stall_D, stall_E, stall_M}), 4'b1111);
            chk($sformatf("mw_flush%0d", i), 32'({flush_D, flush_E, flush_W}), 3'b001);
            tick();
        end
        dmem_ack = 1; #1;
        chk("mw_ack", 32'({stall_F, stall_D, stall_E, stall_M, flush_W}), 0);
        chk("mw_cnt", 32'(stall_cnt), 3);
        tick();
        memreqM = 0; dmem_ack = 0; #1;
        chk("mw_run", 32'({stall_F, stall_D, stall_E, stall_M}), 0);
        chk("mw_cnt2", 32'(stall_cnt), 3);

        // Memory wait outranks load-use (combinational only)
        memreqM = 1; memtoregE = 2'b01; regwriteE = 1; writeregE = 5; rtD = 5; usesrtD = 1;
        #1;
        chk("mw_vs_lu", 32'({flush_D, flush_E, flush_W}), 3'b001);
        clrIn();

        // Timeout: ack never arrives; counter saturates meanwhile
        memreqM = 1; dmem_ack = 0;
        repeat (15) tick();
        chk("to_pre", 32'(mem_err), 0);
        tick();
        chk("to_err", 32'(mem_err), 1);
        chk("to_sat", 32'(stall_cnt), 15);
        tick();
        chk("to_sat_hold", 32'(stall_cnt), 15);
        memreqM = 0; dmem_ack = 1;
        tick();
        dmem_ack = 0;
        tick();
        #1;
        chk("err_sticky", 32'(mem_err), 1);
        chk("err_idle", 32'({stall_F, stall_D, stall_E, stall_M}), 0);

        // Clear has priority over a concurrent stall
        memreqM = 1; clr_cnt = 1; #1;
        chk("clr_stall", 32'(stall_M), 1);
        tick();
        clr_cnt = 0;
        chk("clr_pri", 32'(stall_cnt), 0);
        tick();
        chk("clr_then_inc", 32'(stall_cnt), 1);

        // Reset mid-MWAIT
        memreqM = 0; #1;
        chk("mw_state_hold", 32'(stall_M), 1);
        reset = 0; #1;
        chk("arst_stall", 32'({stall_F, stall_D, stall_E, stall_M}), 0);
        chk("arst_cnt", 32'(stall_cnt), 0);
        chk("arst_err", 32'(mem_err), 0);
        tick();
        reset = 1;
        tick();
        #1;
        chk("post_rst", 32'({stall_F, stall_D, stall_E, stall_M, mem_err}), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
